// File: rtl/sr_mul_seq.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a start/done handshake.
// Optional macro SR_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module sr_mul_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    localparam int unsigned N    = 32 / BITS_PER_CYCLE;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [1:0]             r_op;
    logic                   r_neg;
    logic [31:0]            r_mcand;
    logic [31:0]            r_mplier;
    logic [63:0]            r_acc;
    logic [CntW-1:0]        r_cnt;
    logic [31:0]            r_res;

    logic                   w_sa;
    logic                   w_sb;
    logic [31:0]            w_abs_a;
    logic [31:0]            w_abs_b;
    logic [BITS_PER_CYCLE-1:0] w_bits;
    logic [5:0]             w_sh;
    logic [63:0]            w_pp;
    logic [63:0]            w_acc_nxt;
    logic [63:0]            w_prod;
    logic [31:0]            w_res_nxt;
    logic                   w_last;

    // Signs only matter for the signed operand positions of each op.
    assign w_sa    = ((op == 2'b01) || (op == 2'b10)) && a[31];
    assign w_sb    = (op == 2'b01) && b[31];
    assign w_abs_a = w_sa ? (32'd0 - a) : a;
    assign w_abs_b = w_sb ? (32'd0 - b) : b;

    assign w_bits    = r_mplier[BITS_PER_CYCLE-1:0];
    assign w_sh      = 6'(r_cnt) * 6'(BITS_PER_CYCLE);
    assign w_pp      = {32'd0, r_mcand} * {{(64 - BITS_PER_CYCLE){1'b0}}, w_bits};
    assign w_acc_nxt = r_acc + (w_pp << w_sh);
    assign w_prod    = r_neg ? (64'd0 - w_acc_nxt) : w_acc_nxt;
    assign w_res_nxt = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];

`ifdef SR_MUL_EARLY_EXIT_EN
    assign w_last = (r_cnt == CntW'(N - 1)) || (r_mplier == 32'd0);
`else
    assign w_last = (r_cnt == CntW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_nxt = StBusy;
            StBusy: begin
                // Dropping start aborts; it takes priority over completion.
                if (!start) begin
                    w_state_nxt = StIdle;
                end else if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= 2'b00;
            r_neg    <= 1'b0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= '0;
            r_res    <= 32'd0;
        end else begin
            if (r_state == StIdle && start) begin
                r_op     <= op;
                r_neg    <= w_sa ^ w_sb;
                r_mcand  <= w_abs_a;
                r_mplier <= w_abs_b;
                r_acc    <= 64'd0;
                r_cnt    <= '0;
            end else if (r_state == StBusy && start) begin
                r_acc    <= w_acc_nxt;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_cnt    <= r_cnt + CntW'(1);
                if (w_last) begin
                    r_res <= w_res_nxt;
                end
            end
        end
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);
    assign res  = r_res;

endmodule

// File: tb/tb_sr_mul_seq.sv
// Scoreboard bench for sr_mul_seq: stimulus pushes expected results, a monitor checks each done.
module tb_sr_mul_seq;

    localparam int unsigned BPC = 1;
    localparam int unsigned N   = 32 / BPC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int unsigned cyc    = 0;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [31:0] last_exp = 32'd0;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sr_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .res  (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: full 64-bit product of sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint      lx;
        longint      ly;
        logic [63:0] p;
        lx = (o == 2'b01 || o == 2'b10) ? longint'($signed(x)) : longint'({32'd0, x});
        ly = (o == 2'b01) ? longint'($signed(y)) : longint'({32'd0, y});
        p  = lx * ly;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from accept to done.
    function automatic int unsigned ref_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef SR_MUL_EARLY_EXIT_EN
        logic [31:0] mag;
        int          msb;
        int unsigned nb;
        mag = (o == 2'b01 && y[31]) ? (32'd0 - y) : y;
        if (mag == 32'd0) return 2;
        msb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
        nb = msb / BPC + 2;
        if (nb > N) nb = N;
        return nb + 1;
`else
        if (o == 2'b00 && y == 32'd0) return N + 1;
        return N + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " res"}, res, mon_e.res);
                check({mon_e.name, " done_cycle"}, cyc, mon_e.cyc);
                check({mon_e.name, " busy_in_done"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic go_edge;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the cycle after done.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hold);
        exp_t        e;
        int unsigned k;
        int unsigned nbusy;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        e.res  = ref_mul(o, x, y);
        e.cyc  = cyc + ref_lat(o, y);
        e.name = name;
        sb.push_back(e);
        last_exp = e.res;
        k     = 0;
        nbusy = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 200) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            n_chk++;
            $display("FAIL %s timeout: got no done in %0d cycles, expected done", name, k);
            void'(sb.pop_back());
        end else begin
            // Busy cycles before the done cycle.
            check({name, " busy_cycles"}, nbusy, ref_lat(o, y) - 1);
        end
        go_edge();
        if (!hold) start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset res", res, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        go_edge();

        issue("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        @(negedge clk);
        check("after_done busy", {31'd0, busy}, 32'd0);
        check("after_done done", {31'd0, done}, 32'd0);
        go_edge();

        issue("mulh_m1m1",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue("mulhu_m1m1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue("mul_m1m1",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue("mulhsu_m2x3", 2'b10, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue("mulh_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);

        issue("b2b_2x3", 2'b00, 32'd2, 32'd3, 1'b1);
        issue("b2b_5x5", 2'b00, 32'd5, 32'd5, 1'b0);

        // Abort: start dropped in cycle c+10.
        start = 1'b1;
        op    = 2'b11;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        repeat (10) go_edge();
        start = 1'b0;
        repeat (45) go_edge();
        check("abort res_kept", res, last_exp);
        check("abort busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation in cycle c+20.
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h1234_5678;
        b     = 32'h8000_0001;
        repeat (20) go_edge();
        #1 rst = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset res", res, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        go_edge();
        issue("post_reset", 2'b00, 32'd11, 32'd13, 1'b0);

        issue("early_b0", 2'b00, 32'd123, 32'd0, 1'b0);
        issue("early_b1", 2'b00, 32'd5, 32'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue($sformatf("rand%0d", i), ro, ra, rb, (i != 29) && ($urandom_range(0, 1) == 1));
        end

        repeat (5) go_edge();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_mul_seq.md
Name: sr_mul_seq

Overview:
- Multi-cycle responder for the CPU's multiply-start / result-valid handshake.
- The CPU decodes a multiply-class instruction and holds `start` high with stable operands and op code. It stalls the PC until this block pulses `done` for one cycle with the 32-bit result.
- Iterative shift-add datapath with an explicit FSM.
- Implements the RV32M MUL, MULH, MULHSU and MULHU semantics.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; legal values 1, 2, 4. N = 32/BITS_PER_CYCLE.

Ports:
- clk    input   1   clock, rising edge
- rst    input   1   asynchronous active-low reset
- start  input   1   request; level held by CPU for the whole instruction
- op     input   2   00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- a      input   32  multiplicand (rs1)
- b      input   32  multiplier (rs2 or imm)
- busy   output  1   high in BUSY and DONE states
- done   output  1   one-cycle pulse, result valid
- res    output  32  result; valid when done=1, held until next accept

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, busy=0, done=0, res=0, internal accumulators and counter cleared. Reset mid-operation discards the operation; no done is produced.
- FSM states IDLE, BUSY, DONE.
- IDLE: if start=1 at the clock edge, the request is accepted and the block goes to BUSY:
  - a, b and op are captured.
  - Signed-operand signs are recorded: a is signed for op 01 and 10; b is signed for op 01 only.
  - Magnitudes |a| and |b| are loaded into 32-bit registers; the 64-bit accumulator is cleared; the counter is cleared.
- Accept happens only in IDLE. start=1 observed in BUSY or DONE is never a new request.
- BUSY: each cycle retires BITS_PER_CYCLE low bits of the multiplier register:
  - accumulator += (|a| × those bits) << (counter×BITS_PER_CYCLE);
  - multiplier register shifts right; counter increments.
  - After N BUSY cycles the block goes to DONE.
- BUSY abort: if start=0 during BUSY, the block goes to IDLE next edge. No done is produced and res is unchanged.
- On entry to DONE:
  - product = accumulator, two's-complement negated if sign_a XOR sign_b (signed ops only);
  - res = product[31:0] for op 00, else product[63:32].
  - Registered; done=1 for exactly one cycle.
- DONE → IDLE unconditionally on the next edge.
- The CPU writes the register file and advances the PC in the done cycle.
- A new request can be accepted in the first IDLE cycle after DONE. Back-to-back multiplies cost N+2 cycles each.
- Latency: accept in cycle c (IDLE, start=1); BUSY in cycles c+1..c+N; done=1 in cycle c+N+1. For BITS_PER_CYCLE=1, done is in c+33.
- Arithmetic is full 64-bit internally, with no overflow flag:
  - |−2^31| = 2^31 is represented exactly as unsigned 32-bit;
  - MUL low half is identical for signed and unsigned.
- Outputs are registered. done never asserts without a preceding accept, and never twice per accept.

Optional Feature:
- Macro SR_MUL_EARLY_EXIT_EN.
- Defined: in BUSY, if the remaining multiplier register is zero at the start of a cycle, the block goes directly to DONE on that edge. The result is unchanged.
  - Minimum latency: done in cycle c+2, e.g. for b=0.
  - Maximum latency: still c+N+1.
- Undefined: fixed latency of N BUSY cycles regardless of operand values.

Test Plan:
1. op=00, a=7, b=6, start held → done=1 exactly in cycle c+33 (BITS_PER_CYCLE=1), res=42; busy=1 in c+1..c+33, busy=0 and done=0 in c+34.
2. a=b=0xFFFFFFFF:
   - op=01 → res=0x00000000 (−1×−1=1);
   - op=11 → res=0xFFFFFFFE;
   - op=00 → res=0x00000001.
3. op=10, a=0xFFFFFFFE (−2), b=3 → res=0xFFFFFFFF; op=01, a=0x80000000, b=0x80000000 → res=0x40000000.
4. Back-to-back: start held high across two consecutive MUL requests (2×3, then 5×5) → res=6 with done in c+33, then IDLE accept in c+34, res=25 with done in c+67; exactly two done pulses.
5. Abort and reset:
   - start dropped in cycle c+10 → no done, res retains its old value;
   - rst=0 asynchronously in cycle c+20 of another operation → busy, done and res go to 0 immediately, and a new request is accepted after reset release.
6. SR_MUL_EARLY_EXIT_EN defined: a=123, b=0 → done in c+2, res=0; a=5, b=1 → done in c+3, res=5. Undefined: both cases complete in c+33.
